// File: rtl/winograd_output_transform_acc.sv
// Channel-accumulating Winograd output transform Y = A^T*M*A, F(4x4,3x3) or F(2x2,3x3).
// Latency: last beat accepted in cycle c -> out_valid from c+3; in_ready low from last beat until tile_out handshakes.
module winograd_output_transform_acc #(
  parameter int IN_W     = 32,
  parameter int ACC_W    = 40,
  parameter int OUT_W    = 32,
  parameter bit SATURATE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic                  mode,
  input  logic [36*IN_W-1:0]    tile_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*OUT_W-1:0]   tile_out,
  output logic                  out_mode,
  output logic                  overflow,
  output logic                  busy
);

  localparam int TW = ACC_W + 5;
  localparam int YW = ACC_W + 10;

  localparam logic [1:0] S_ACC = 2'd0;
  localparam logic [1:0] S_ROW = 2'd1;
  localparam logic [1:0] S_COL = 2'd2;
  localparam logic [1:0] S_OUT = 2'd3;

  logic [1:0]               state;
  logic                     started;
  logic                     mode_q;
  logic                     accept;
  logic signed [IN_W-1:0]   in_el  [36];
  logic signed [ACC_W-1:0]  acc    [36];
  logic signed [TW-1:0]     t_n    [24];
  logic signed [TW-1:0]     t_q    [24];
  logic signed [YW-1:0]     y_full [16];
  logic signed [OUT_W-1:0]  y_lo   [16];
  logic signed [OUT_W-1:0]  y_conv [16];
  logic [15:0]              y_ovf;
  logic [16*OUT_W-1:0]      y_pack;

  // One row of A^T dotted with a 6-vector; mode 1 only looks at v0..v3.
  function automatic logic signed [YW-1:0] at_dot(
    input logic                 m,
    input int                   i,
    input logic signed [YW-1:0] v0, v1, v2, v3, v4, v5
  );
    logic signed [YW-1:0] r;
    r = '0;
    if (!m) begin
      case (i)
        0:       r = v0 + v1 + v2 + v3 + v4;
        1:       r = v1 - v2 + (v3 <<< 1) - (v4 <<< 1);
        2:       r = v1 + v2 + (v3 <<< 2) + (v4 <<< 2);
        3:       r = v1 - v2 + (v3 <<< 3) - (v4 <<< 3) + v5;
        default: r = '0;
      endcase
    end else begin
      case (i)
        0:       r = v0 + v1 + v2;
        1:       r = v1 - v2 - v3;
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  assign in_ready = (state == S_ACC) && !rst;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != S_ACC) || started;

  always_comb begin
    for (int k = 0; k < 36; k++) begin
      in_el[k] = tile_in[k*IN_W +: IN_W];
    end
  end

  // T = A^T * acc, stored row-major as 4 rows x 6 columns.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 6; j++) begin
        t_n[i*6+j] = TW'(at_dot(mode_q, i,
                                YW'(acc[0*6+j]), YW'(acc[1*6+j]), YW'(acc[2*6+j]),
                                YW'(acc[3*6+j]), YW'(acc[4*6+j]), YW'(acc[5*6+j])));
      end
    end
  end

  // Y = T * A: column j of A is row j of A^T.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        y_full[i*4+j] = at_dot(mode_q, j,
                               YW'(t_q[i*6+0]), YW'(t_q[i*6+1]), YW'(t_q[i*6+2]),
                               YW'(t_q[i*6+3]), YW'(t_q[i*6+4]), YW'(t_q[i*6+5]));
        if (mode_q && (i >= 2 || j >= 2)) begin
          y_full[i*4+j] = '0;
        end
      end
    end
  end

  always_comb begin
    y_pack = '0;
    for (int e = 0; e < 16; e++) begin
      y_lo[e]  = y_full[e][OUT_W-1:0];
      y_ovf[e] = (y_full[e] != YW'(y_lo[e]));
      if (SATURATE && y_ovf[e]) begin
        y_conv[e] = y_full[e][YW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end else begin
        y_conv[e] = y_lo[e];
      end
      y_pack[e*OUT_W +: OUT_W] = y_conv[e];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_ACC;
      started   <= 1'b0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      overflow  <= 1'b0;
      tile_out  <= '0;
      for (int k = 0; k < 36; k++) acc[k] <= '0;
      for (int k = 0; k < 24; k++) t_q[k] <= '0;
    end else begin
      case (state)
        S_ACC: begin
          if (accept) begin
            // First beat of a tile overwrites, later beats add; mode is frozen after the first.
            for (int k = 0; k < 36; k++) begin
              acc[k] <= started ? acc[k] + ACC_W'(in_el[k]) : ACC_W'(in_el[k]);
            end
            if (!started) mode_q <= mode;
            started <= 1'b1;
            if (in_last) state <= S_ROW;
          end
        end
        S_ROW: begin
          for (int k = 0; k < 24; k++) t_q[k] <= t_n[k];
          state <= S_COL;
        end
        S_COL: begin
          tile_out  <= y_pack;
          out_valid <= 1'b1;
          out_mode  <= mode_q;
          overflow  <= |y_ovf;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            started   <= 1'b0;
            state     <= S_ACC;
          end
        end
        default: state <= S_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_winograd_output_transform_acc.sv
// Bench: saturating and wrapping instances share one input stream and are checked against a matrix model.
module tb_winograd_output_transform_acc;

  localparam int IN_W  = 20;
  localparam int ACC_W = 22;
  localparam int OUT_W = 16;

  logic                 clk = 1'b0;
  logic                 rst, in_valid, in_last, mode, out_ready;
  logic [36*IN_W-1:0]   in_tile;
  logic                 s_in_ready, s_out_valid, s_out_mode, s_ovf, s_busy;
  logic                 w_in_ready, w_out_valid, w_out_mode, w_ovf, w_busy;
  logic [16*OUT_W-1:0]  s_tile, w_tile;

  winograd_output_transform_acc #(.IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_last(in_last),
    .mode(mode), .tile_in(in_tile), .out_valid(s_out_valid), .out_ready(out_ready),
    .tile_out(s_tile), .out_mode(s_out_mode), .overflow(s_ovf), .busy(s_busy));

  winograd_output_transform_acc #(.IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .in_last(in_last),
    .mode(mode), .tile_in(in_tile), .out_valid(w_out_valid), .out_ready(out_ready),
    .tile_out(w_tile), .out_mode(w_out_mode), .overflow(w_ovf), .busy(w_busy));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit rnd_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  int at0 [4][6] = '{'{1, 1, 1, 1, 1, 0}, '{0, 1, -1, 2, -2, 0},
                     '{0, 1, 1, 4, 4, 0}, '{0, 1, -1, 8, -8, 1}};
  int at1 [2][4] = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};

  // Reference state
  longint macc [36];
  bit     mstarted = 1'b0;
  bit     mmode = 1'b0;
  bit     pend = 1'b0;
  longint exp_s [16];
  longint exp_w [16];
  bit     exp_ovf, exp_md;
  int     exp_vcyc;

  function automatic void chk(string nm, int idx, logic [63:0] act, logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s[%0d] got %0d want %0d (t=%0t)", nm, idx, $signed(act), $signed(expv), $time);
    end
  endfunction

  function automatic longint wrapw(longint v, int w);
    longint r;
    r = v <<< (64 - w);
    return r >>> (64 - w);
  endfunction

  function automatic logic [63:0] el(logic [16*OUT_W-1:0] v, int e);
    logic signed [OUT_W-1:0] x;
    x = v[e*OUT_W +: OUT_W];
    return {{(64-OUT_W){x[OUT_W-1]}}, x};
  endfunction

  function automatic int atv(bit m, int i, int k);
    return m ? at1[i][k] : at0[i][k];
  endfunction

  function automatic void model_out();
    longint t [4][6];
    longint y, lo, hi_lim, lo_lim;
    int n, r;
    n = mmode ? 4 : 6;
    r = mmode ? 2 : 4;
    hi_lim = (64'sd1 <<< (OUT_W - 1)) - 1;
    lo_lim = -(64'sd1 <<< (OUT_W - 1));
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 6; j++) t[i][j] = 0;
    for (int i = 0; i < r; i++)
      for (int j = 0; j < n; j++)
        for (int k = 0; k < n; k++) t[i][j] += atv(mmode, i, k) * macc[k*6+j];
    exp_ovf = 1'b0;
    exp_md  = mmode;
    for (int e = 0; e < 16; e++) begin
      exp_s[e] = 0;
      exp_w[e] = 0;
    end
    for (int i = 0; i < r; i++)
      for (int j = 0; j < r; j++) begin
        y = 0;
        for (int k = 0; k < n; k++) y += t[i][k] * atv(mmode, j, k);
        lo = wrapw(y, OUT_W);
        if (lo != y) exp_ovf = 1'b1;
        exp_w[i*4+j] = lo;
        exp_s[i*4+j] = (y > hi_lim) ? hi_lim : (y < lo_lim) ? lo_lim : y;
      end
  endfunction

  // Per-cycle compare against the model, then advance the model past the coming edge.
  initial begin
    bit eov, erdy;
    logic signed [IN_W-1:0] x;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("in_ready_rst_s", 0, 64'(s_in_ready), 0);
        chk("in_ready_rst_w", 0, 64'(w_in_ready), 0);
        mstarted = 1'b0;
        pend     = 1'b0;
      end else begin
        eov  = pend && (cyc >= exp_vcyc);
        erdy = !pend;
        chk("out_valid_s", cyc, 64'(s_out_valid), 64'(eov));
        chk("out_valid_w", cyc, 64'(w_out_valid), 64'(eov));
        chk("in_ready_s", cyc, 64'(s_in_ready), 64'(erdy));
        chk("in_ready_w", cyc, 64'(w_in_ready), 64'(erdy));
        chk("busy_s", cyc, 64'(s_busy), 64'(mstarted || pend));
        chk("busy_w", cyc, 64'(w_busy), 64'(mstarted || pend));
        if (eov) begin
          chk("out_mode", cyc, 64'(s_out_mode), 64'(exp_md));
          chk("out_mode_w", cyc, 64'(w_out_mode), 64'(exp_md));
          chk("overflow_s", cyc, 64'(s_ovf), 64'(exp_ovf));
          chk("overflow_w", cyc, 64'(w_ovf), 64'(exp_ovf));
          for (int e = 0; e < 16; e++) begin
            chk("tile_sat", e, el(s_tile, e), exp_s[e]);
            chk("tile_wrap", e, el(w_tile, e), exp_w[e]);
          end
        end
        if (in_valid && erdy) begin
          for (int k = 0; k < 36; k++) begin
            x = in_tile[k*IN_W +: IN_W];
            macc[k] = mstarted ? wrapw(macc[k] + longint'(x), ACC_W) : longint'(x);
          end
          if (!mstarted) mmode = mode;
          mstarted = 1'b1;
          if (in_last) begin
            model_out();
            pend     = 1'b1;
            exp_vcyc = cyc + 3;
          end
        end
        if (eov && out_ready) begin
          pend     = 1'b0;
          mstarted = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic fill(input int v);
    for (int k = 0; k < 36; k++) in_tile[k*IN_W +: IN_W] = IN_W'(v);
  endtask

  task automatic send(input bit m, input bit last);
    bit ok;
    int n;
    in_valid = 1'b1;
    in_last  = last;
    mode     = m;
    n = 0;
    forever begin
      @(negedge clk);
      ok = s_in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 0, 1, 0);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!s_out_valid && lat < 60);
    if (!s_out_valid) chk("out_timeout", 0, 0, 1);
  endtask

  task automatic handshake();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, nb, v, drain;
    int e1 [16];
    int e2 [16];
    logic [16*OUT_W-1:0] held;
    e1 = '{25, 0, 50, 5, 0, 0, 0, 0, 50, 0, 100, 10, 5, 0, 10, 1};
    e2 = '{9, -3, 0, 0, -3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; mode = 1'b0; out_ready = 1'b1;
    in_tile = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", 0, 64'(s_out_valid), 0);
    chk("rst_busy", 0, 64'(s_busy), 0);
    chk("rst_tile_zero", 0, 64'(s_tile == '0), 1);
    chk("rst_overflow", 0, 64'(s_ovf), 0);
    chk("rst_out_mode", 0, 64'(s_out_mode), 0);
    handshake();

    // Single beat, mode 0, all ones
    fill(1);
    send(0, 1);
    wait_out(lat);
    chk("t1_latency", 0, 64'(lat), 3);
    chk("t1_overflow", 0, 64'(s_ovf), 0);
    for (int e = 0; e < 16; e++) chk("t1_tile", e, el(s_tile, e), 64'(longint'(e1[e])));
    handshake();

    // Single beat, mode 1
    fill(1);
    send(1, 1);
    wait_out(lat);
    chk("t2_out_mode", 0, 64'(s_out_mode), 1);
    for (int e = 0; e < 16; e++) chk("t2_tile", e, el(w_tile, e), 64'(longint'(e2[e])));
    handshake();

    // Three channels, mode toggled on later beats
    fill(1);
    send(0, 0);
    send(1, 0);
    send(1, 1);
    wait_out(lat);
    chk("t3_y00", 0, el(s_tile, 0), 75);
    chk("t3_y22", 10, el(s_tile, 10), 300);
    chk("t3_out_mode", 0, 64'(s_out_mode), 0);
    handshake();

    // Backpressure hold
    out_ready = 1'b0;
    fill(1);
    send(0, 1);
    wait_out(lat);
    held = s_tile;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", i, 64'(s_out_valid), 1);
      chk("t4_hold_in_ready", i, 64'(s_in_ready), 0);
      chk("t4_hold_tile", i, 64'(s_tile == held), 1);
      chk("t4_hold_ovf", i, 64'(s_ovf), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_in_ready_after", 0, 64'(s_in_ready), 1);
    handshake();

    // Output range: saturate versus wrap
    fill(1000);
    send(0, 1);
    wait_out(lat);
    chk("t5_sat_y22", 10, el(s_tile, 10), 32767);
    chk("t5_sat_y00", 0, el(s_tile, 0), 25000);
    chk("t5_sat_ovf", 0, 64'(s_ovf), 1);
    chk("t5_wrap_y22", 10, el(w_tile, 10), -64'sd31072);
    chk("t5_wrap_ovf", 0, 64'(w_ovf), 1);
    handshake();

    // Reset in the middle of a tile
    fill(1);
    send(0, 0);
    send(0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send(0, 1);
    wait_out(lat);
    for (int e = 0; e < 16; e++) chk("t6_tile", e, el(s_tile, e), 64'(longint'(e1[e])));
    handshake();
    @(negedge clk);
    chk("t6_busy_after", 0, 64'(s_busy), 0);
    handshake();

    // Random tiles, random channel counts, gaps and backpressure
    rnd_rdy = 1'b1;
    for (int t = 0; t < 80; t++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 1)) handshake();
        for (int k = 0; k < 36; k++) begin
          case ($urandom_range(0, 2))
            0: v = $urandom_range(0, 100) - 50;
            1: v = $urandom_range(0, 8000) - 4000;
            default: v = $urandom;
          endcase
          in_tile[k*IN_W +: IN_W] = IN_W'(v);
        end
        send((b == 0) ? (t % 2 == 1) : 1'($urandom_range(0, 1)), b == nb - 1);
      end
    end
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    drain = 0;
    while (pend && drain < 200) begin
      @(negedge clk);
      drain++;
    end
    if (pend) chk("drain_timeout", 0, 1, 0);
    repeat (3) handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
